// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive path.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_OVS       = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: oversampled frame FSM, shift register and valid/ready output stage.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int OVS       = DEFAULT_OVS
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;
`else
  localparam rx_state_e AFTER_DATA = STOP;
`endif

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e            state_reg, state_next;
  logic [SW-1:0]        sample_cnt_reg, sample_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_bad_reg, parity_bad_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_err_reg, overrun_err_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 deliver;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      sample_cnt_reg  <= '0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      parity_bad_reg  <= 1'b0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      overrun_err_reg <= 1'b0;
      parity_err_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sample_cnt_reg  <= sample_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      parity_bad_reg  <= parity_bad_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      frame_err_reg   <= frame_err_next;
      overrun_err_reg <= overrun_err_next;
      parity_err_reg  <= parity_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    sample_cnt_next  = sample_cnt_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    parity_bad_next  = parity_bad_reg;
    rx_data_next     = rx_data_reg;
    rx_valid_next    = rx_valid_reg;
    frame_err_next   = 1'b0;
    overrun_err_next = 1'b0;
    parity_err_next  = 1'b0;
    deliver          = 1'b0;

    if (rx_valid_reg && rx_ready) begin
      rx_valid_next = 1'b0;
    end

    if (!rx_en) begin
      // Disabling mid-frame drops the partial byte silently.
      state_next      = IDLE;
      sample_cnt_next = '0;
    end else if (baud_tick) begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next      = START;
            sample_cnt_next = '0;
            parity_bad_next = 1'b0;
          end
        end
        START: begin
          if (sample_cnt_reg == HALF_LAST) begin
            sample_cnt_next = '0;
            bit_cnt_next    = '0;
            state_next      = rx_s ? IDLE : DATA;
          end else begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (sample_cnt_reg == FULL_LAST) begin
            sample_cnt_next = '0;
            shift_next      = {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt_next    = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
              state_next = AFTER_DATA;
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_cnt_reg == FULL_LAST) begin
            sample_cnt_next = '0;
            state_next      = STOP;
            if (rx_s != ((^shift_reg) ^ PARITY_ODD)) begin
              parity_err_next = 1'b1;
              parity_bad_next = 1'b1;
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (sample_cnt_reg == FULL_LAST) begin
            sample_cnt_next = '0;
            state_next      = IDLE;
            // A parity failure already flagged this frame; stay silent.
            if (!parity_bad_reg) begin
              if (rx_s) begin
                deliver = 1'b1;
              end else begin
                frame_err_next = 1'b1;
              end
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next      = IDLE;
          sample_cnt_next = '0;
        end
      endcase
    end

    if (deliver) begin
      if (!rx_valid_reg || rx_ready) begin
        rx_data_next  = shift_reg;
        rx_valid_next = 1'b1;
      end else begin
        overrun_err_next = 1'b1;
      end
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_err_reg;
  assign parity_err  = parity_err_reg;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed plus random frame bench for uart_rx_sequencer with a byte-level scoreboard.
module tb_uart_rx_sequencer;

  localparam int DB   = 8;
  localparam int OVS  = 16;
  localparam int TDIV = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          baud_tick = 1'b0;
  logic          rx_en = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;

  int total = 0;
  int bad   = 0;

  int fe_seen = 0;
  int ov_seen = 0;
  int pe_seen = 0;
  logic [DB-1:0] got_q[$];

  logic          exp_valid = 1'b0;
  logic [DB-1:0] exp_data  = '0;
  int exp_fe = 0;
  int exp_ov = 0;
  int exp_pe = 0;
  logic [DB-1:0] exp_q[$];

  uart_rx_sequencer #(.DATA_BITS(DB), .OVS(OVS)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .rx_en       (rx_en),
    .rx          (rx),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      baud_tick = (div == TDIV - 1);
      div = (div + 1) % TDIV;
    end
  end

  // Observes handshakes and error pulses a little after the falling edge.
  always @(negedge clk) begin
    #2;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err)   fe_seen++;
    if (overrun_err) ov_seen++;
    if (parity_err)  pe_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic hold_ticks(input int n);
    repeat (n * TDIV) @(negedge clk);
  endtask

  // Drives one frame LSB first, then one bit time of idle line.
  task automatic send_frame(input logic [DB-1:0] data, input logic par_bit,
                            input logic stop_bit, input logic ready_in_stop);
    rx = 1'b0;
    hold_ticks(OVS);
    for (int i = 0; i < DB; i++) begin
      rx = data[i];
      hold_ticks(OVS);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    hold_ticks(OVS);
`else
    rx = rx | (par_bit & 1'b0);
`endif
    rx = stop_bit;
    if (ready_in_stop) rx_ready = 1'b1;
    hold_ticks(OVS);
    rx = 1'b1;
    hold_ticks(OVS);
    rx_ready = 1'b0;
    hold_ticks(2);
  endtask

  // Reference outcome of a completed frame with the consumer idle.
  task automatic model_frame(input logic [DB-1:0] data, input logic par_ok, input logic stop_bit);
    if (!par_ok)          exp_pe++;
    else if (!stop_bit)   exp_fe++;
    else if (exp_valid)   exp_ov++;
    else begin
      exp_valid = 1'b1;
      exp_data  = data;
    end
  endtask

  task automatic read_byte();
    @(negedge clk);
    rx_ready = 1'b1;
    if (exp_valid) begin
      exp_q.push_back(exp_data);
      exp_valid = 1'b0;
    end
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, 32'(rx_valid), 32'(exp_valid));
    check({tag, ".data"}, 32'(rx_data), 32'(exp_data));
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".frame_err"}, 32'(fe_seen), 32'(exp_fe));
    check({tag, ".overrun"}, 32'(ov_seen), 32'(exp_ov));
    check({tag, ".parity_err"}, 32'(pe_seen), 32'(exp_pe));
    check({tag, ".accepted"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, ".accepted_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    $display("txn %s: valid=%0d data=%02h fe=%0d ov=%0d pe=%0d", tag, rx_valid, rx_data,
             fe_seen, ov_seen, pe_seen);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          stop_b;
    logic          flip;

    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_state("reset");
    check("reset.frame_err_pin", 32'(frame_err), 32'd0);
    rx_en = 1'b1;
    hold_ticks(4);

    // Clean frame, consumer not ready.
    send_frame(8'hA5, ^8'hA5, 1'b1, 1'b0);
    model_frame(8'hA5, 1'b1, 1'b1);
    check_state("frame_a5");

    // Start bit too short to survive the mid-bit check.
    rx = 1'b0;
    hold_ticks(4);
    rx = 1'b1;
    hold_ticks(2 * OVS);
    check_state("glitch");
    read_byte();
    check_state("read_a5");

    // Stop bit held low.
    send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_state("frame_err_3c");

    // Unread byte followed by another frame.
    send_frame(8'h11, ^8'h11, 1'b1, 1'b0);
    model_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1, 1'b0);
    model_frame(8'h22, 1'b1, 1'b1);
    check_state("overrun_22");

    // Consumer ready through the stop bit: old byte taken, new one taken too.
    send_frame(8'h22, ^8'h22, 1'b1, 1'b1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_valid = 1'b0;
    exp_data  = 8'h22;
    check_state("ready_at_stop");

    // Pending byte, then reset part way through a frame.
    send_frame(8'h77, ^8'h77, 1'b1, 1'b0);
    model_frame(8'h77, 1'b1, 1'b1);
    rx = 1'b0;
    hold_ticks(OVS);
    rx = 1'b1;
    hold_ticks(3 * OVS);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    reset = 1'b1;
    exp_valid = 1'b0;
    exp_data  = '0;
    hold_ticks(OVS);
    check_state("mid_reset");
    send_frame(8'h5A, ^8'h5A, 1'b1, 1'b0);
    model_frame(8'h5A, 1'b1, 1'b1);
    check_state("after_reset_5a");
    read_byte();

    // Receiver disabled part way through a frame.
    rx = 1'b0;
    hold_ticks(OVS);
    rx = 1'b0;
    hold_ticks(3 * OVS);
    rx_en = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rx_en = 1'b1;
    hold_ticks(OVS);
    check_state("rx_en_abort");
    send_frame(8'h5A, ^8'h5A, 1'b1, 1'b0);
    model_frame(8'h5A, 1'b1, 1'b1);
    check_state("after_abort_5a");
    read_byte();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    model_frame(8'h07, 1'b0, 1'b1);
    check_state("parity_bad_07");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b1);
    check_state("parity_ok_07");
    read_byte();
`endif

    for (int n = 0; n < 24; n++) begin
      d      = DB'($urandom);
      stop_b = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 4) == 0);
`else
      flip = 1'b0;
`endif
      send_frame(d, (^d) ^ flip, stop_b, 1'b0);
      model_frame(d, !flip, stop_b);
      check_state($sformatf("rand%0d", n));
      if ($urandom_range(0, 2) != 0) read_byte();
    end
    read_byte();
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
